// File: rtl/deep_task_decoder.sv
// Inverse of the deep task-logic datapath: finds which action code(s) reproduce an observed
// result for a given operand pair, testing one candidate action per cycle.
module deep_task_decoder #(
    parameter bit STOP_ON_FIRST = 1'b0
) (
    input  logic       dtl_clk,
    input  logic       dtl_rst_n,
    input  logic       dtl_in_valid,
    output logic       dtl_in_ready,
    input  logic [7:0] dtl_in_a,
    input  logic [7:0] dtl_in_b,
    input  logic [7:0] dtl_in_result,
    output logic       dtl_out_valid,
    input  logic       dtl_out_ready,
    output logic [3:0] dtl_out_mask,
    output logic [1:0] dtl_out_action,
    output logic       dtl_out_found,
    output logic [7:0] dtl_err_count
);

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StDone
    } state_e;

    state_e     state_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [7:0] result_q;
    logic [3:0] mask_q;
    logic [1:0] idx_q;

    logic       hit;
    logic       last;
    logic [3:0] mask_next;
    logic [1:0] action_next;

    // Forward model of the task-logic datapath for one action code.
    function automatic logic [7:0] forward(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] k);
        logic [7:0] t;
        unique case (k)
            2'd3:    t = a + b;
            2'd1:    t = a - b;
            2'd2:    t = a & b;
            default: t = a | b;
        endcase
        unique case (t[1:0])
            2'b00:   return t ^ 8'hFF;
            2'b01:   return t + 8'd1;
            2'b10:   return t - 8'd1;
            default: return t;
        endcase
    endfunction

    always_comb begin
        hit            = (forward(a_q, b_q, idx_q) == result_q);
        mask_next      = mask_q;
        mask_next[idx_q] = hit;
        last           = (idx_q == 2'd3) || (STOP_ON_FIRST && hit);
        action_next    = 2'd0;
        if (mask_next[0]) begin
            action_next = 2'd0;
        end else if (mask_next[1]) begin
            action_next = 2'd1;
        end else if (mask_next[2]) begin
            action_next = 2'd2;
        end else if (mask_next[3]) begin
            action_next = 2'd3;
        end
    end

    always_ff @(posedge dtl_clk or negedge dtl_rst_n) begin
        if (!dtl_rst_n) begin
            state_q        <= StIdle;
            a_q            <= 8'h00;
            b_q            <= 8'h00;
            result_q       <= 8'h00;
            mask_q         <= 4'h0;
            idx_q          <= 2'd0;
            dtl_in_ready   <= 1'b0;
            dtl_out_valid  <= 1'b0;
            dtl_out_mask   <= 4'h0;
            dtl_out_action <= 2'd0;
            dtl_out_found  <= 1'b0;
            dtl_err_count  <= 8'h00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (dtl_in_valid && dtl_in_ready) begin
                        a_q          <= dtl_in_a;
                        b_q          <= dtl_in_b;
                        result_q     <= dtl_in_result;
                        mask_q       <= 4'h0;
                        idx_q        <= 2'd0;
                        dtl_in_ready <= 1'b0;
                        state_q      <= StEval;
                    end else begin
                        dtl_in_ready <= 1'b1;
                    end
                end
                StEval: begin
                    mask_q <= mask_next;
                    idx_q  <= idx_q + 2'd1;
                    if (last) begin
                        dtl_out_valid  <= 1'b1;
                        dtl_out_mask   <= mask_next;
                        dtl_out_found  <= |mask_next;
                        dtl_out_action <= action_next;
                        state_q        <= StDone;
                    end
                end
                StDone: begin
                    if (dtl_out_ready) begin
                        dtl_out_valid <= 1'b0;
                        if (!dtl_out_found && dtl_err_count != 8'hFF) begin
                            dtl_err_count <= dtl_err_count + 8'd1;
                        end
                        dtl_in_ready <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_deep_task_decoder.sv
// Directed bench for deep_task_decoder: one instance searching all actions, one stopping on
// the first match, driven from a vector table plus backpressure, reset and saturation sequences.
module tb_deep_task_decoder;

    logic       dtl_clk;
    logic       dtl_rst_n;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [7:0] in_result;

    logic       in_valid,  s_in_valid;
    logic       in_ready,  s_in_ready;
    logic       out_valid, s_out_valid;
    logic       out_ready, s_out_ready;
    logic [3:0] out_mask,  s_out_mask;
    logic [1:0] out_action, s_out_action;
    logic       out_found, s_out_found;
    logic [7:0] err_count, s_err_count;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] err_m0 = 8'h00;
    logic [7:0] err_m1 = 8'h00;

    deep_task_decoder #(.STOP_ON_FIRST(1'b0)) dut (
        .dtl_clk        (dtl_clk),
        .dtl_rst_n      (dtl_rst_n),
        .dtl_in_valid   (in_valid),
        .dtl_in_ready   (in_ready),
        .dtl_in_a       (in_a),
        .dtl_in_b       (in_b),
        .dtl_in_result  (in_result),
        .dtl_out_valid  (out_valid),
        .dtl_out_ready  (out_ready),
        .dtl_out_mask   (out_mask),
        .dtl_out_action (out_action),
        .dtl_out_found  (out_found),
        .dtl_err_count  (err_count)
    );

    deep_task_decoder #(.STOP_ON_FIRST(1'b1)) dut_sof (
        .dtl_clk        (dtl_clk),
        .dtl_rst_n      (dtl_rst_n),
        .dtl_in_valid   (s_in_valid),
        .dtl_in_ready   (s_in_ready),
        .dtl_in_a       (in_a),
        .dtl_in_b       (in_b),
        .dtl_in_result  (in_result),
        .dtl_out_valid  (s_out_valid),
        .dtl_out_ready  (s_out_ready),
        .dtl_out_mask   (s_out_mask),
        .dtl_out_action (s_out_action),
        .dtl_out_found  (s_out_found),
        .dtl_err_count  (s_err_count)
    );

    initial dtl_clk = 1'b0;
    always #5 dtl_clk = ~dtl_clk;

    typedef struct {
        bit         sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic [3:0] mask;
        logic [1:0] act;
        bit         found;
        int         lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_req(input bit sel, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] r, input logic [3:0] emask, input logic [1:0] eact,
                           input bit efound, input int elat);
        int n;
        int lat;
        n = 0;
        @(negedge dtl_clk);
        while (!(sel ? s_in_ready : in_ready) && n < 20) begin
            @(negedge dtl_clk);
            n++;
        end
        chk("in_ready_wait", {31'd0, sel ? s_in_ready : in_ready}, 32'd1);
        in_a = a;
        in_b = b;
        in_result = r;
        if (sel) s_in_valid = 1'b1;
        else in_valid = 1'b1;
        @(posedge dtl_clk);
        #1;
        in_valid = 1'b0;
        s_in_valid = 1'b0;
        chk("in_ready_drop", {31'd0, sel ? s_in_ready : in_ready}, 32'd0);
        lat = 0;
        while (!(sel ? s_out_valid : out_valid) && lat < 10) begin
            @(posedge dtl_clk);
            #1;
            lat++;
        end
        chk("latency", lat, elat);
        chk("mask", {28'd0, sel ? s_out_mask : out_mask}, {28'd0, emask});
        chk("action", {30'd0, sel ? s_out_action : out_action}, {30'd0, eact});
        chk("found", {31'd0, sel ? s_out_found : out_found}, {31'd0, efound});
        @(negedge dtl_clk);
        if (sel) s_out_ready = 1'b1;
        else out_ready = 1'b1;
        @(posedge dtl_clk);
        #1;
        out_ready = 1'b0;
        s_out_ready = 1'b0;
        if (sel) begin
            if (!efound && err_m1 != 8'hFF) err_m1 = err_m1 + 8'd1;
            chk("err_count", {24'd0, s_err_count}, {24'd0, err_m1});
            chk("out_valid_drop", {31'd0, s_out_valid}, 32'd0);
        end else begin
            if (!efound && err_m0 != 8'hFF) err_m0 = err_m0 + 8'd1;
            chk("err_count", {24'd0, err_count}, {24'd0, err_m0});
            chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        logic [3:0] hold_mask;
        logic [1:0] hold_act;
        logic       hold_found;
        int         n;

        vecs[0]  = '{0, 8'h10, 8'h05, 8'h16, 4'b1001, 2'd0, 1, 4};
        vecs[1]  = '{0, 8'h10, 8'h05, 8'h0B, 4'b0010, 2'd1, 1, 4};
        vecs[2]  = '{0, 8'h10, 8'h05, 8'hFF, 4'b0100, 2'd2, 1, 4};
        vecs[3]  = '{0, 8'h10, 8'h05, 8'h00, 4'b0000, 2'd0, 0, 4};
        vecs[4]  = '{0, 8'h00, 8'h01, 8'hFF, 4'b0110, 2'd1, 1, 4};
        vecs[5]  = '{0, 8'h00, 8'h01, 8'h02, 4'b1001, 2'd0, 1, 4};
        vecs[6]  = '{0, 8'hFF, 8'h01, 8'hFD, 4'b0010, 2'd1, 1, 4};
        vecs[7]  = '{1, 8'h10, 8'h05, 8'h16, 4'b0001, 2'd0, 1, 1};
        vecs[8]  = '{1, 8'h10, 8'h05, 8'h0B, 4'b0010, 2'd1, 1, 2};
        vecs[9]  = '{1, 8'h10, 8'h05, 8'hFF, 4'b0100, 2'd2, 1, 3};
        vecs[10] = '{1, 8'h10, 8'h05, 8'h00, 4'b0000, 2'd0, 0, 4};
        vecs[11] = '{1, 8'h00, 8'h01, 8'hFF, 4'b0010, 2'd1, 1, 2};
        vecs[12] = '{1, 8'hFF, 8'h01, 8'h02, 4'b0100, 2'd2, 1, 3};

        dtl_rst_n = 1'b0;
        in_valid = 1'b0;
        s_in_valid = 1'b0;
        out_ready = 1'b0;
        s_out_ready = 1'b0;
        in_a = 8'h00;
        in_b = 8'h00;
        in_result = 8'h00;

        // Reset state.
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mask", {28'd0, out_mask}, 32'd0);
        chk("rst_err", {24'd0, err_count}, 32'd0);
        chk("rst_sof_in_ready", {31'd0, s_in_ready}, 32'd0);
        @(negedge dtl_clk);
        dtl_rst_n = 1'b1;
        @(posedge dtl_clk);
        #1;
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            run_req(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].mask, vecs[i].act,
                    vecs[i].found, vecs[i].lat);
        end

        // Backpressure: response must hold while the consumer stalls.
        @(negedge dtl_clk);
        in_a = 8'h10;
        in_b = 8'h05;
        in_result = 8'h0B;
        in_valid = 1'b1;
        @(posedge dtl_clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge dtl_clk);
            #1;
            n++;
        end
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        hold_mask = 4'b0010;
        hold_act = 2'd1;
        hold_found = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge dtl_clk);
            in_valid = 1'b1;
            in_result = 8'h16;
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_mask", {28'd0, out_mask}, {28'd0, hold_mask});
            chk("bp_hold_action", {30'd0, out_action}, {30'd0, hold_act});
            chk("bp_hold_found", {31'd0, out_found}, {31'd0, hold_found});
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        @(negedge dtl_clk);
        out_ready = 1'b1;
        @(posedge dtl_clk);
        #1;
        out_ready = 1'b0;
        chk("bp_in_ready_rise", {31'd0, in_ready}, 32'd1);
        chk("bp_valid_drop", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a search abandons it.
        @(negedge dtl_clk);
        in_result = 8'h00;
        in_valid = 1'b1;
        @(posedge dtl_clk);
        #1;
        in_valid = 1'b0;
        @(posedge dtl_clk);
        #2;
        dtl_rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_mask", {28'd0, out_mask}, 32'd0);
        chk("mid_rst_action", {30'd0, out_action}, 32'd0);
        chk("mid_rst_found", {31'd0, out_found}, 32'd0);
        chk("mid_rst_err", {24'd0, err_count}, 32'd0);
        err_m0 = 8'h00;
        err_m1 = 8'h00;
        @(negedge dtl_clk);
        dtl_rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge dtl_clk);
            #1;
            if (out_valid) n++;
        end
        chk("no_resp_after_rst", n, 0);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);

        // Saturation of the no-match counter.
        for (int i = 0; i < 300; i++) begin
            run_req(1'b0, 8'h10, 8'h05, 8'h00, 4'b0000, 2'd0, 1'b0, 4);
        end
        chk("err_saturated", {24'd0, err_count}, 32'h0000_00FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/deep_task_decoder.md
Name: deep_task_decoder

Overview:
- Inverse of the deep task-logic datapath: given an operand pair and an observed 8-bit result, searches all four action codes and reports which action(s) reproduce the result.
- Used by scoreboards and the result-checking path downstream of the task-logic register.
- Evaluates one candidate action per cycle through a small FSM, with valid/ready handshakes on input and output and a saturating no-match counter.

Parameters:
- STOP_ON_FIRST, 0, 1 = terminate the search at the first matching action; 0 = always evaluate all four.

Ports:
- dtl_clk  input  1  clock
- dtl_rst_n  input  1  reset, asynchronous, active-low
- dtl_in_valid  input  1  request valid
- dtl_in_ready  output  1  decoder can accept a request
- dtl_in_a  input  8  operand A
- dtl_in_b  input  8  operand B
- dtl_in_result  input  8  observed result to explain
- dtl_out_valid  output  1  response valid
- dtl_out_ready  input  1  consumer accepts response
- dtl_out_mask  output  4  bit k set = action k reproduces result
- dtl_out_action  output  2  lowest-index matching action; 0 when none
- dtl_out_found  output  1  at least one match
- dtl_err_count  output  8  saturating count of completed no-match responses

Behaviour:
- Forward function f(a,b,k), all arithmetic mod 256. Stage 1:
  - k=3: a+b
  - k=1: a-b
  - k=2: a&b
  - k=0: a|b
- Stage 2 maps on the stage-1 low 2 bits t[1:0]:
  - 00: t^8'hFF
  - 01: t+1
  - 10: t-1
  - 11: t
- Reset (async, active-low): state IDLE; all outputs 0, including dtl_in_ready. Operand, mask and index registers are cleared. Reset mid-search abandons the transaction with no response.
- dtl_in_ready is registered. It becomes 1 on the first edge after reset release and is 1 only in IDLE.
- FSM states: IDLE, EVAL, DONE.
- IDLE:
  - At an edge with dtl_in_valid && dtl_in_ready: capture a, b and result; clear the mask; idx=0; dtl_in_ready<=0; go to EVAL.
- EVAL:
  - Each edge: mask[idx] <= (f(a,b,idx)==result); idx increments.
  - Leave for DONE after idx 3 has been evaluated. With STOP_ON_FIRST=1, leave on the edge where the first match is registered; higher mask bits stay 0.
  - On the DONE transition: dtl_out_valid<=1; dtl_out_mask, dtl_out_found and dtl_out_action are loaded together.
  - Latency with STOP_ON_FIRST=0: exactly 4 edges from acceptance to dtl_out_valid high.
  - Latency with STOP_ON_FIRST=1: 1-4 edges, equal to the index of the first match plus 1, or 4 if there is no match.
- DONE:
  - Outputs are held stable while dtl_out_valid && !dtl_out_ready.
  - At an edge with dtl_out_ready: dtl_out_valid<=0; if found=0, dtl_err_count increments, saturating at 8'hFF; dtl_in_ready<=1; return to IDLE.
  - There is no same-cycle re-accept, so minimum request spacing is 6 cycles.
- Input changes while dtl_in_ready=0 are ignored. dtl_out_valid never drops without a handshake, except on reset.
- dtl_err_count is cleared only by reset.

Test Plan:
- a=8'h10, b=8'h05, result=8'h16, STOP_ON_FIRST=0 -> out_valid exactly 4 edges after accept; mask=4'b1001, action=0, found=1.
- Same operands:
  - result=8'h0B -> mask=4'b0010, action=1.
  - result=8'hFF -> mask=4'b0100, action=2.
  - result=8'h00 -> mask=4'b0000, found=0, action=0; err_count 0->1 at the output handshake.
- Wrap/borrow: a=8'h00, b=8'h01, result=8'hFF -> mask=4'b0110, action=1. Then result=8'h02 -> mask=4'b1001.
- STOP_ON_FIRST=1, a=8'h10, b=8'h05, result=8'h16 -> out_valid 1 edge after accept; mask=4'b0001, action=0.
- Backpressure and reset:
  - Hold dtl_out_ready=0 for 10 cycles -> outputs stable and in_ready=0 throughout; in_ready rises one edge after the handshake.
  - Assert dtl_rst_n low mid-EVAL -> all outputs 0 immediately; no response after release.
- Saturation: 300 back-to-back no-match requests -> err_count sticks at 8'hFF.
